// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: FIFO of fetched {pc, instr} pairs between IF and ID, emptied by a taken branch.
module if_prefetch_queue #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  input  logic             out_ready,
  output logic [PTR_W:0]   count
);
  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;
  assign in_ready  = count != (PTR_W+1)'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign out_pc    = out_valid ? mem[rd_ptr][63:32] : 32'd0;
  assign out_instr = out_valid ? mem[rd_ptr][31:0] : 32'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + PTR_W'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + PTR_W'(1) : rd_ptr;
      count  <= (push & ~pop) ? count + (PTR_W+1)'(1) :
                (pop & ~push) ? count - (PTR_W+1)'(1) : count;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_pc, in_instr};
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: directed checks of fill, drain, streaming, wrap, flush and async reset.
module tb_if_prefetch_queue;
  logic        clk = 0, rst = 1, in_valid = 0, flush = 0, out_ready = 0;
  logic [31:0] in_pc = 0, in_instr = 0;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_instr;
  logic [2:0]  count;
  int errors = 0, checks = 0;
  if_prefetch_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_ready(out_ready), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #3;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    #4 rst = 0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_pc = 32'(4 * i); in_instr = 32'hE000_0000 | 32'(i);
      step;
    end
    chk("fill_count", 32'(count), 4);
    chk("fill_in_ready", 32'(in_ready), 0);
    chk("fill_out_pc", out_pc, 4);
    chk("fill_out_instr", out_instr, 32'hE000_0001);
    in_pc = 20; in_instr = 32'hE000_0005;
    step;
    chk("full_push_count", 32'(count), 4);
    chk("full_push_head", out_pc, 4);
    in_valid = 0; out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_pc", out_pc, 32'(4 * i));
      chk("drain_instr", out_instr, 32'hE000_0000 | 32'(i));
      step;
    end
    chk("drain_out_valid", 32'(out_valid), 0);
    chk("drain_out_pc", out_pc, 0);
    chk("drain_out_instr", out_instr, 0);
    chk("drain_count", 32'(count), 0);
    chk("drain_in_ready", 32'(in_ready), 1);
    step;
    chk("empty_pop_count", 32'(count), 0);
    in_valid = 1;
    for (int k = 0; k < 20; k++) begin
      in_pc = 32'(100 + 4 * k); in_instr = 32'hA000_0000 + 32'(k);
      step;
      chk("stream_count", 32'(count), 1);
      chk("stream_pc", out_pc, 32'(100 + 4 * k));
    end
    in_valid = 0;
    step;
    chk("stream_end_count", 32'(count), 0);
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_pc = 32'h200 + 32'(4 * i); in_instr = 32'hB000_0000 + 32'(i);
      step;
    end
    chk("wrap_count3", 32'(count), 3);
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      chk("wrap_pop_pc", out_pc, 32'h200 + 32'(4 * i));
      step;
    end
    out_ready = 0; in_valid = 1;
    for (int i = 2; i < 6; i++) begin
      in_pc = 32'h200 + 32'(4 * (i + 1)); in_instr = 32'hB000_0000 + 32'(i + 1);
      step;
    end
    chk("wrap_full_count", 32'(count), 4);
    in_valid = 0; out_ready = 1;
    for (int i = 2; i < 6; i++) begin
      chk("wrap_order_pc", out_pc, 32'h200 + 32'(4 * i));
      chk("wrap_order_instr", out_instr, 32'hB000_0000 + 32'(i));
      step;
    end
    chk("wrap_empty", 32'(out_valid), 0);
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_pc = 32'h300 + 32'(4 * i); in_instr = 32'hC000_0000 + 32'(i);
      step;
    end
    chk("pre_flush_count", 32'(count), 3);
    in_pc = 32'h30C; out_ready = 1; flush = 1;
    step;
    chk("flush_count", 32'(count), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    flush = 0; out_ready = 0; in_pc = 32'h40; in_instr = 32'hD000_0040;
    step;
    chk("post_flush_pc", out_pc, 32'h40);
    chk("post_flush_instr", out_instr, 32'hD000_0040);
    chk("post_flush_count", 32'(count), 1);
    in_pc = 32'h44; in_instr = 32'hD000_0044;
    step;
    chk("pre_rst_count", 32'(count), 2);
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 0);
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_out_pc", out_pc, 0);
    rst = 0;
    step;
    in_valid = 1; in_pc = 32'h50; in_instr = 32'hD000_0050;
    step;
    in_valid = 0;
    chk("post_rst_count", 32'(count), 1);
    chk("post_rst_pc", out_pc, 32'h50);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
